regmap_arbiter: RTL and testbench
=================================

REGMAP_ARBITER -- requirements
Module: regmap_arbiter

Interface
REQ-001 SHALL have parameter NUMREGS, default 16, number of 8-bit configuration registers.
REQ-002 SHALL have parameter WPROT_MASK, NUMREGS bits wide, default all zeros, per-register write-protect against port 1; used only when REGMAP_ARB_WPROT_EN is defined.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 req  input  2  per-port access request; port 0 is the UART command path, port 1 is the on-chip calibration sequencer.
REQ-007 we  input  2  per-port write enable (1 = write, 0 = read).
REQ-008 addr  input  2x8  per-port register address.
REQ-009 wdata  input  2x8  per-port write data.
REQ-010 gnt  output  2  one-hot one-cycle grant pulse.
REQ-011 ack  output  2  one-hot one-cycle completion pulse.
REQ-012 rdata  output  8  shared read data, valid only while ack is high.
REQ-013 err  output  1  one-cycle pulse, coincident with ack, on a rejected access.
REQ-014 reg_we  output  1  register-file write strobe.
REQ-015 reg_addr  output  8  register-file address.
REQ-016 reg_wdata  output  8  register-file write data.
REQ-017 reg_rdata  input  8  register-file combinational read data.

Function
REQ-018 SHALL implement a three-state FSM:
- IDLE: any req goes to ACCESS.
- ACCESS: always goes to RESP.
- RESP: always goes to IDLE.
REQ-019 In IDLE, a winner SHALL be selected and its we, addr and wdata latched, using round-robin. A single requester wins outright. When both request, the port not granted last wins.
REQ-020 In ACCESS, SHALL pulse gnt for the winner and drive reg_addr and reg_wdata from the latched values.
REQ-021 In ACCESS, reg_we SHALL assert for one cycle only for a legal write.
REQ-022 In ACCESS, reg_rdata SHALL be captured into rdata for a legal read.
REQ-023 In RESP, SHALL pulse ack for the winner and, if the access was rejected, err.
REQ-024 Latency: req sampled at cycle N gives gnt at N+1 and ack at N+2. Maximum throughput is one access per 3 cycles.
REQ-025 Requesters SHALL hold req, we, addr and wdata stable until gnt. A requester SHALL deassert req in the cycle after gnt, or a new access begins.
REQ-026 addr >= NUMREGS SHALL be rejected: no reg_we, rdata = 0x00, err = 1.
REQ-027 A req that drops while the FSM is in ACCESS or RESP SHALL NOT affect the access in flight.
REQ-028 Back-to-back contention SHALL alternate grants: both req held gives the grant order 0,1,0,1.
REQ-029 rdata SHALL hold its value outside ack. reg_addr and reg_wdata SHALL hold their last values when idle.

Reset
REQ-030 While reset is high:
- FSM = IDLE.
- gnt, ack, err and reg_we = 0.
- rdata, reg_addr and reg_wdata = 0x00.
- last-grant pointer = 1, so port 0 wins the first tie.
REQ-031 Reset asserted during ACCESS or RESP SHALL abort the access: no reg_we pulse after the reset edge, and no ack.

Configuration
REQ-032 The macro REGMAP_ARB_WPROT_EN SHALL control write protection.
- Defined: a port-1 write to address a with WPROT_MASK[a] = 1 is rejected (no reg_we, err = 1, ack still given). Port-0 writes and all reads are unaffected.
- Undefined: WPROT_MASK is ignored and no protection logic is generated.

Structure
REQ-033 Package nanocmos_regmap_pkg SHALL hold:
- the FSM state enum (IDLE, ACCESS, RESP);
- NUM_PORTS = 2;
- REG_ADDR_W = 8;
- REG_DATA_W = 8.
REQ-034 Round-robin selection SHALL be the sub-module regmap_rr_pick: inputs req and the last-grant pointer, output a one-hot winner.

Verification
REQ-035 Port 0 writes 0xA5 to address 3 -> gnt[0] at N+1, reg_we with reg_addr = 3 and reg_wdata = 0xA5 in the same cycle, ack[0] at N+2, err = 0.
REQ-036 Port 1 reads address 5 with reg_rdata = 0x3C -> gnt[1] at N+1, ack[1] with rdata = 0x3C at N+2.
REQ-037 Both ports request continuously from reset -> grants in order 0,1,0,1, each 3 cycles apart, with no lost access.
REQ-038 Port 0 writes to address 16 with NUMREGS = 16 -> no reg_we, ack[0] with err = 1. A read of address 20 returns rdata = 0x00 with err = 1.
REQ-039 With REGMAP_ARB_WPROT_EN defined and WPROT_MASK[0] = 1:
- port-1 write to address 0 -> no reg_we, err = 1;
- port-0 write to address 0 -> succeeds.
REQ-040 Reset asserted in the ACCESS cycle of a write -> no ack. On the next request after reset, port 0 wins the tie.

Source files
------------

// File: rtl/nanocmos_regmap_pkg.sv
// Shared types and widths for the two-port register-map arbiter.
package nanocmos_regmap_pkg;

    localparam int unsigned NUM_PORTS  = 2;
    localparam int unsigned REG_ADDR_W = 8;
    localparam int unsigned REG_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

endpackage

// File: rtl/regmap_rr_pick.sv
// Two-port round-robin winner select; on a tie the port not granted last wins.
module regmap_rr_pick
    import nanocmos_regmap_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 last,
    output logic [NUM_PORTS-1:0] win
);

    always_comb begin
        win = '0;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last ? 2'b01 : 2'b10;
            default: win = '0;
        endcase
    end

endmodule

// File: rtl/regmap_arbiter.sv
// Two-port arbiter in front of an 8-bit configuration register file.
// Optional port-1 write protection is built only when REGMAP_ARB_WPROT_EN is defined.
module regmap_arbiter
    import nanocmos_regmap_pkg::*;
#(
    parameter int unsigned        NUMREGS    = 16,
    parameter logic [NUMREGS-1:0] WPROT_MASK = '0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_PORTS-1:0]                 req,
    input  logic [NUM_PORTS-1:0]                 we,
    input  logic [NUM_PORTS-1:0][REG_ADDR_W-1:0] addr,
    input  logic [NUM_PORTS-1:0][REG_DATA_W-1:0] wdata,
    output logic [NUM_PORTS-1:0]                 gnt,
    output logic [NUM_PORTS-1:0]                 ack,
    output logic [REG_DATA_W-1:0]                rdata,
    output logic                                 err,
    output logic                                 reg_we,
    output logic [REG_ADDR_W-1:0]                reg_addr,
    output logic [REG_DATA_W-1:0]                reg_wdata,
    input  logic [REG_DATA_W-1:0]                reg_rdata
);

    state_t               state;
    logic                 last;
    logic [NUM_PORTS-1:0] win;
    logic [NUM_PORTS-1:0] lat_port;
    logic                 lat_rd;
    logic                 lat_rej;

    logic                  sel;
    logic                  sel_we;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic                  in_range;
    logic                  sel_prot;
    logic                  sel_rej;

    regmap_rr_pick u_pick (
        .req  (req),
        .last (last),
        .win  (win)
    );

    assign sel      = win[1];
    assign sel_we   = we[sel];
    assign sel_addr = addr[sel];
    assign in_range = 32'(sel_addr) < NUMREGS;

`ifdef REGMAP_ARB_WPROT_EN
    logic [NUMREGS-1:0] prot_bits;
    assign prot_bits = WPROT_MASK >> sel_addr;
    assign sel_prot  = sel && sel_we && prot_bits[0];
`else
    assign sel_prot  = 1'b0;
`endif

    assign sel_rej = !in_range || sel_prot;

    // Legality is resolved while leaving IDLE so every strobe is a plain register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            gnt       <= '0;
            ack       <= '0;
            err       <= 1'b0;
            reg_we    <= 1'b0;
            rdata     <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            lat_port  <= '0;
            lat_rd    <= 1'b0;
            lat_rej   <= 1'b0;
        end else begin
            gnt    <= '0;
            ack    <= '0;
            err    <= 1'b0;
            reg_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state     <= ACCESS;
                        gnt       <= win;
                        last      <= sel;
                        reg_addr  <= sel_addr;
                        reg_wdata <= wdata[sel];
                        reg_we    <= sel_we && !sel_rej;
                        lat_port  <= win;
                        lat_rd    <= !sel_we && !sel_rej;
                        lat_rej   <= sel_rej;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    ack   <= lat_port;
                    err   <= lat_rej;
                    if (lat_rd) begin
                        rdata <= reg_rdata;
                    end else if (lat_rej) begin
                        rdata <= '0;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regmap_arbiter.sv
// Directed scoreboard bench for regmap_arbiter with a behavioural 16-entry register file.
// Expectations for port-1 protected writes follow REGMAP_ARB_WPROT_EN.
module tb_regmap_arbiter;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req;
    logic [1:0]       we;
    logic [1:0][7:0]  addr;
    logic [1:0][7:0]  wdata;
    logic [1:0]       gnt;
    logic [1:0]       ack;
    logic [7:0]       rdata;
    logic             err;
    logic             reg_we;
    logic [7:0]       reg_addr;
    logic [7:0]       reg_wdata;
    logic [7:0]       reg_rdata;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cyc = 0;

    logic [7:0] rf [16] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h3C, 8'h16, 8'h17,
                            8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F};

    typedef struct {
        logic [1:0]  port;
        logic        err;
        logic [7:0]  rdata;
        logic        chk_rd;
        int unsigned gcyc;
    } exp_t;

    exp_t sb[$];

`ifdef REGMAP_ARB_WPROT_EN
    localparam logic PROT_ON = 1'b1;
`else
    localparam logic PROT_ON = 1'b0;
`endif

    regmap_arbiter #(
        .NUMREGS    (16),
        .WPROT_MASK (16'h0001)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .ack       (ack),
        .rdata     (rdata),
        .err       (err),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reg_we && reg_addr < 8'd16) rf[reg_addr[3:0]] <= reg_wdata;
    end

    assign reg_rdata = (reg_addr < 8'd16) ? rf[reg_addr[3:0]] : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_unexpected_ack"}, 32'(ack), 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_ack"}, 32'(ack), 32'(e.port));
        chk({tag, "_err"}, 32'(err), 32'(e.err));
        if (e.chk_rd) chk({tag, "_rdata"}, 32'(rdata), 32'(e.rdata));
        chk({tag, "_ack_lat"}, cyc - e.gcyc, 32'd1);
    endtask

    // One isolated access: gnt must appear one cycle after req is sampled, ack one after that.
    task automatic do_access(input string tag, input int p, input logic w, input logic [7:0] a,
                             input logic [7:0] d, input logic exp_err, input logic [7:0] exp_rd);
        logic [1:0] oh;
        logic       got;
        exp_t       e;
        oh = (p == 0) ? 2'b01 : 2'b10;
        @(negedge clk);
        req      = oh;
        we[p]    = w;
        addr[p]  = a;
        wdata[p] = d;
        @(posedge clk); #1;
        chk({tag, "_gnt"}, 32'(gnt), 32'(oh));
        chk({tag, "_reg_we"}, 32'(reg_we), 32'(w && !exp_err));
        chk({tag, "_reg_addr"}, 32'(reg_addr), 32'(a));
        if (w) chk({tag, "_reg_wdata"}, 32'(reg_wdata), 32'(d));
        e.port   = oh;
        e.err    = exp_err;
        e.rdata  = exp_rd;
        e.chk_rd = !w || (a >= 8'd16);
        e.gcyc   = cyc;
        sb.push_back(e);
        req = 2'b00;
        got = 1'b0;
        for (int k = 0; k < 4 && !got; k++) begin
            @(posedge clk); #1;
            chk({tag, "_reg_we_single"}, 32'(reg_we), 32'd0);
            if (ack != 2'b00) begin
                got = 1'b1;
                pop_check(tag);
            end
        end
        chk({tag, "_ack_seen"}, 32'(got), 32'd1);
        @(posedge clk); #1;
        chk({tag, "_ack_low"}, 32'(ack), 32'd0);
    endtask

    initial begin
        int unsigned ngnt;
        int unsigned nack;
        int unsigned last_g;
        exp_t        e;

        reset = 1'b1;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_reg_we", 32'(reg_we), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_reg_addr", 32'(reg_addr), 32'd0);
        chk("rst_reg_wdata", 32'(reg_wdata), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        do_access("p0_wr3", 0, 1'b1, 8'd3, 8'hA5, 1'b0, 8'h00);
        do_access("p1_rd5", 1, 1'b0, 8'd5, 8'h00, 1'b0, 8'h3C);
        @(posedge clk); #1;
        chk("rdata_hold", 32'(rdata), 32'h3C);
        do_access("p0_rd3", 0, 1'b0, 8'd3, 8'h00, 1'b0, 8'hA5);
        do_access("p0_wr16", 0, 1'b1, 8'd16, 8'h77, 1'b1, 8'h00);
        do_access("p1_rd20", 1, 1'b0, 8'd20, 8'h00, 1'b1, 8'h00);
        do_access("p1_rd15", 1, 1'b0, 8'd15, 8'h00, 1'b0, 8'h1F);
        do_access("p1_wr0", 1, 1'b1, 8'd0, 8'h5A, PROT_ON, 8'h00);
        do_access("p1_rd0", 1, 1'b0, 8'd0, 8'h00, 1'b0, PROT_ON ? 8'h10 : 8'h5A);
        do_access("p0_wr0", 0, 1'b1, 8'd0, 8'hC3, 1'b0, 8'h00);
        do_access("p0_rd0", 0, 1'b0, 8'd0, 8'h00, 1'b0, 8'hC3);

        // Reset in the ACCESS cycle of a port-0 write: no ack, and port 0 wins the next tie.
        @(negedge clk);
        req      = 2'b01;
        we[0]    = 1'b1;
        addr[0]  = 8'd7;
        wdata[0] = 8'h99;
        @(posedge clk); #1;
        chk("abort_gnt", 32'(gnt), 32'd1);
        req   = 2'b00;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_no_ack", 32'(ack), 32'd0);
        chk("abort_no_we", 32'(reg_we), 32'd0);
        chk("abort_reg_addr", 32'(reg_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort_still_no_ack", 32'(ack), 32'd0);
        @(negedge clk);
        req   = 2'b11;
        we    = 2'b00;
        addr  = {8'd2, 8'd1};
        @(posedge clk); #1;
        chk("abort_tie_gnt", 32'(gnt), 32'd1);
        req = 2'b00;
        repeat (3) @(posedge clk);

        // Continuous contention from reset: grants 0,1,0,1 three cycles apart, every ack delivered.
        @(negedge clk);
        reset = 1'b1;
        req   = 2'b11;
        we    = 2'b00;
        addr  = {8'd2, 8'd1};
        repeat (2) @(posedge clk);
        #1;
        chk("cont_rst_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        ngnt   = 0;
        nack   = 0;
        last_g = 0;
        for (int k = 0; k < 20 && nack < 4; k++) begin
            @(posedge clk); #1;
            if (gnt != 2'b00) begin
                chk("cont_gnt_order", 32'(gnt), (ngnt % 2 == 0) ? 32'd1 : 32'd2);
                if (ngnt > 0) chk("cont_gnt_spacing", cyc - last_g, 32'd3);
                e.port   = gnt;
                e.err    = 1'b0;
                e.rdata  = gnt[0] ? 8'h11 : 8'h12;
                e.chk_rd = 1'b1;
                e.gcyc   = cyc;
                sb.push_back(e);
                last_g = cyc;
                ngnt++;
                if (ngnt == 4) req = 2'b00;
            end
            if (ack != 2'b00) begin
                pop_check("cont");
                nack++;
            end
        end
        chk("cont_grants", ngnt, 32'd4);
        chk("cont_acks", nack, 32'd4);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
